// File: rtl/rf_pkg.sv
// Shared register-file constants and the write-scheduler state encoding.
package rf_pkg;
  localparam int RF_AW = 4;
  localparam int RF_DW = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SETUP  = ST_SETUP,
    S_STROBE = ST_STROBE
  } state_t;
endpackage

// File: rtl/regfile_wr_sched_if.sv
// Requester handshake plus register-file write port bundle for regfile_wr_sched.
interface regfile_wr_sched_if #(
  parameter int NREQ = 3,
  parameter int AW   = rf_pkg::RF_AW,
  parameter int DW   = rf_pkg::RF_DW
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]      write_addr;
  logic [DW-1:0]      write_data;
  logic               reg_wr;
  logic               busy;
  logic [1:0]         grant_id;
  logic               r0_drop;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, write_addr, write_data, reg_wr, busy, grant_id, r0_drop
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, write_addr, write_data, reg_wr, busy, grant_id, r0_drop
  );
endinterface

// File: rtl/regfile_wr_sched_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      gnt_idx,
  output logic            any
);
  logic [1:0] sel;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sel     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel = 2'((int'(ptr) + k) % NREQ);
      if (en && !any && req[sel]) begin
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
        any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_wr_sched.sv
// Shares the register-file write port between NREQ sources with a setup-then-strobe sequence.
// Optional r0 write suppression: define REGWR_R0_GUARD_EN.
module regfile_wr_sched
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input logic               clk,
  input logic               rst_n,
  regfile_wr_sched_if.slave bus
);
  state_t          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [1:0]      gid_q, gid_d;
  logic            reg_wr_q, reg_wr_d;
  logic            r0_drop_q, r0_drop_d;
  logic            en, any;
  logic [NREQ-1:0] gnt;
  logic [1:0]      gnt_idx;

  // Accepting in STROBE lets the next write overlap the current strobe.
  assign en = (state_q == S_IDLE) || (state_q == S_STROBE);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .en      (en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    gid_d     = gid_q;
    reg_wr_d  = 1'b0;
    r0_drop_d = 1'b0;
    case (state_q)
      S_IDLE, S_STROBE: begin
        if (any) begin
          state_d = S_SETUP;
          ptr_d   = (gnt_idx == 2'(NREQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
          addr_d  = bus.req_addr[int'(gnt_idx)*AW +: AW];
          data_d  = bus.req_data[int'(gnt_idx)*DW +: DW];
          gid_d   = gnt_idx;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
`ifdef REGWR_R0_GUARD_EN
        if (addr_q == '0) begin
          r0_drop_d = 1'b1;
        end else begin
          reg_wr_d = 1'b1;
        end
`else
        reg_wr_d = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      gid_q     <= '0;
      reg_wr_q  <= 1'b0;
      r0_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      gid_q     <= gid_d;
      reg_wr_q  <= reg_wr_d;
      r0_drop_q <= r0_drop_d;
    end
  end

  assign bus.req_ready  = gnt;
  assign bus.write_addr = addr_q;
  assign bus.write_data = data_q;
  assign bus.reg_wr     = reg_wr_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.grant_id   = gid_q;
  assign bus.r0_drop    = r0_drop_q;
endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched with a per-cycle behavioural model and literal spot checks.
module tb_regfile_wr_sched;
  localparam int NREQ = 3;
  localparam int AW   = 4;
  localparam int DW   = 16;
`ifdef REGWR_R0_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  regfile_wr_sched_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  regfile_wr_sched #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = no write pending, 1 = one cycle after accept, 2 = strobe cycle.
  int              m_phase;
  int              m_ptr;
  int              m_gid;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;

  always @(negedge clk) begin
    int              win;
    logic [NREQ-1:0] exp_rdy;
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0; m_gid = 0; m_addr = '0; m_data = '0;
      chk("rst_reg_wr", 32'(bus.reg_wr), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_addr", 32'(bus.write_addr), 0);
    end else begin
      win = -1;
      if (m_phase != 1) begin
        for (int k = 0; k < NREQ; k++) begin
          if (win < 0 && bus.req_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
        end
      end
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("m_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("m_addr", 32'(bus.write_addr), 32'(m_addr));
      chk("m_data", 32'(bus.write_data), 32'(m_data));
      chk("m_gid", 32'(bus.grant_id), 32'(m_gid));
      chk("m_busy", 32'(bus.busy), 32'(m_phase != 0));
      chk("m_reg_wr", 32'(bus.reg_wr), 32'(m_phase == 2 && !(GUARD && m_addr == 0)));
      chk("m_r0_drop", 32'(bus.r0_drop), 32'(GUARD && m_phase == 2 && m_addr == 0));
      if (win >= 0) begin
        m_addr  = bus.req_addr[win*AW +: AW];
        m_data  = bus.req_data[win*DW +: DW];
        m_gid   = win;
        m_ptr   = (win + 1) % NREQ;
        m_phase = 1;
        $display("xfer req=%0d addr=%0h data=%04h t=%0t", win, m_addr, m_data, $time);
      end else begin
        m_phase = (m_phase == 1) ? 2 : 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int grants[$];
  int saddr[$];
  int scyc[$];
  int exp_g[4] = '{0, 1, 2, 0};
  int exp_a[4] = '{5, 6, 7, 5};
  int exp_c[4] = '{2, 4, 6, 8};

  initial begin
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    #2;
    chk("init_reg_wr", 32'(bus.reg_wr), 0);
    chk("init_grant", 32'(bus.grant_id), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Three-way contention
    step();
    bus.req_valid = 3'b111;
    bus.req_addr  = {4'd7, 4'd6, 4'd5};
    bus.req_data  = {16'h0707, 16'h0606, 16'h0505};
    for (int c = 0; c < 10; c++) begin
      if (c == 7) bus.req_valid = '0;
      #1;
      for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) grants.push_back(i);
      if (bus.reg_wr) begin
        saddr.push_back(int'(bus.write_addr));
        scyc.push_back(c);
      end
      step();
    end
    chk("cont_ngrant", 32'(grants.size()), 4);
    chk("cont_nstrobe", 32'(saddr.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) chk("cont_grant", 32'(grants[i]), 32'(exp_g[i]));
      if (i < saddr.size())  chk("cont_saddr", 32'(saddr[i]), 32'(exp_a[i]));
      if (i < scyc.size())   chk("cont_scyc", 32'(scyc[i]), 32'(exp_c[i]));
    end
    repeat (2) step();

    // Single request from requester 1
    bus.req_valid = 3'b010;
    bus.req_addr[4 +: 4]   = 4'd3;
    bus.req_data[16 +: 16] = 16'h00AA;
    #1 chk("single_ready", 32'(bus.req_ready), 32'b010);
    step();
    bus.req_valid = '0;
    chk("single_addr", 32'(bus.write_addr), 3);
    chk("single_data", 32'(bus.write_data), 32'h00AA);
    chk("single_wr0", 32'(bus.reg_wr), 0);
    chk("single_gid", 32'(bus.grant_id), 1);
    step();
    chk("single_wr1", 32'(bus.reg_wr), 1);
    step();
    chk("single_wr_fall", 32'(bus.reg_wr), 0);
    chk("single_idle", 32'(bus.busy), 0);

    // Back-to-back from requester 2
    step();
    bus.req_valid = 3'b100;
    bus.req_addr[8 +: 4]   = 4'd9;
    bus.req_data[32 +: 16] = 16'h1111;
    #1 chk("b2b_ready1", 32'(bus.req_ready), 32'b100);
    step();
    bus.req_data[32 +: 16] = 16'h2222;
    #1 chk("b2b_setup_ready", 32'(bus.req_ready), 0);
    step();
    #1 chk("b2b_ready2", 32'(bus.req_ready), 32'b100);
    chk("b2b_strobe1", 32'(bus.reg_wr), 1);
    chk("b2b_data1", 32'(bus.write_data), 32'h1111);
    step();
    bus.req_valid = '0;
    chk("b2b_data2_setup", 32'(bus.write_data), 32'h2222);
    chk("b2b_wr_low", 32'(bus.reg_wr), 0);
    step();
    chk("b2b_strobe2", 32'(bus.reg_wr), 1);
    step();
    chk("b2b_idle", 32'(bus.busy), 0);

    // Reset during SETUP
    step();
    bus.req_valid = 3'b010;
    bus.req_addr[4 +: 4]   = 4'd4;
    bus.req_data[16 +: 16] = 16'h1234;
    step();
    bus.req_valid = '0;
    chk("rstmid_busy", 32'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_reg_wr", 32'(bus.reg_wr), 0);
    chk("rstmid_busy0", 32'(bus.busy), 0);
    chk("rstmid_addr", 32'(bus.write_addr), 0);
    chk("rstmid_data", 32'(bus.write_data), 0);
    chk("rstmid_gid", 32'(bus.grant_id), 0);
    step();
    chk("rstmid_hold_wr", 32'(bus.reg_wr), 0);
    rst_n = 1'b1;
    #1 bus.req_valid = 3'b111;
    #1 chk("rstmid_first_grant", 32'(bus.req_ready), 32'b001);
    step();
    bus.req_valid = '0;
    repeat (3) step();

    // Write to r0 from requester 0
    bus.req_valid = 3'b001;
    bus.req_addr[0 +: 4]  = 4'd0;
    bus.req_data[0 +: 16] = 16'hFFFF;
    #1 chk("r0_ready", 32'(bus.req_ready), 32'b001);
    step();
    bus.req_valid = '0;
    chk("r0_addr", 32'(bus.write_addr), 0);
    chk("r0_data", 32'(bus.write_data), 32'hFFFF);
    step();
    chk("r0_reg_wr", 32'(bus.reg_wr), GUARD ? 32'd0 : 32'd1);
    chk("r0_drop", 32'(bus.r0_drop), GUARD ? 32'd1 : 32'd0);
    step();
    chk("r0_drop_end", 32'(bus.r0_drop), 0);
    chk("r0_wr_end", 32'(bus.reg_wr), 0);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
